// File: rtl/lane_deskew_n.sv
// N-lane CSI-2 byte-lane deskew: measures lane start skew at packet start and
// delays early lanes through per-lane tap lines so one aligned word emerges per cycle.
module lane_deskew_n #(
    parameter int LANES    = 2,
    parameter int MAX_SKEW = 3,
    parameter int SKW_W    = $clog2(MAX_SKEW + 1)
) (
    input  logic                   sclk,
    input  logic                   s_rst,
    input  logic [LANES*8-1:0]     lane_byte_data,
    input  logic [LANES-1:0]       lane_byte_vld,
    input  logic                   packet_done,
    output logic [LANES*8-1:0]     word_data,
    output logic                   word_vld,
    output logic                   skew_err,
    output logic [LANES*SKW_W-1:0] lane_tap
);

    typedef enum logic [1:0] {IDLE, CAPTURE, ALIGNED, DRAIN} state_t;

    state_t             r_state, w_next;
    logic [SKW_W-1:0]   r_cnt, w_cntInc, w_curCnt;
    logic [LANES-1:0]   r_seen, w_seenPrev, w_seenNext, w_newArr;
    logic [SKW_W-1:0]   r_arr    [LANES];
    logic [SKW_W-1:0]   r_tap    [LANES];
    logic [SKW_W-1:0]   w_arrEff [LANES];
    logic [SKW_W-1:0]   w_newTap [LANES];
    logic [SKW_W-1:0]   w_selTap [LANES];
    logic [7:0]         r_dly    [LANES][MAX_SKEW];
    logic [LANES*8-1:0] w_word;
    logic               w_enterAligned, w_timeout, w_emit;

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // In IDLE the arrival count is 0; in CAPTURE it is one past the stored count.
    always_comb begin
        w_cntInc   = r_cnt + SKW_W'(1);
        w_curCnt   = (r_state == CAPTURE) ? w_cntInc : '0;
        w_seenPrev = (r_state == CAPTURE) ? r_seen : '0;
        w_seenNext = w_seenPrev | lane_byte_vld;
        w_newArr   = lane_byte_vld & ~w_seenPrev;
        w_next         = r_state;
        w_enterAligned = 1'b0;
        w_timeout      = 1'b0;
        w_emit         = 1'b0;
        case (r_state)
            IDLE: begin
                if (&lane_byte_vld) begin
                    w_next         = ALIGNED;
                    w_enterAligned = 1'b1;
                end else if (|lane_byte_vld) begin
                    w_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (packet_done) begin
                    w_next = DRAIN;
                end else if (&w_seenNext) begin
                    w_next         = ALIGNED;
                    w_enterAligned = 1'b1;
                end else if (w_cntInc == SKW_W'(MAX_SKEW)) begin
                    w_next    = DRAIN;
                    w_timeout = 1'b1;
                end
            end
            ALIGNED: begin
                if (packet_done) w_next = DRAIN;
                else             w_emit = 1'b1;
            end
            DRAIN: begin
                if (~|lane_byte_vld) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_enterAligned) w_emit = 1'b1;
    end

    // The entry cycle already emits the first word, so it selects with the fresh taps.
    always_comb begin
        w_word = lane_byte_data;
        for (int i = 0; i < LANES; i++) begin
            w_arrEff[i] = w_newArr[i] ? w_curCnt : r_arr[i];
            w_newTap[i] = w_curCnt - w_arrEff[i];
            w_selTap[i] = w_enterAligned ? w_newTap[i] : r_tap[i];
            for (int k = 1; k <= MAX_SKEW; k++) begin
                if (w_selTap[i] == SKW_W'(k)) w_word[8*i +: 8] = r_dly[i][k-1];
            end
        end
    end

    always_comb begin
        lane_tap = '0;
        for (int i = 0; i < LANES; i++) lane_tap[i*SKW_W +: SKW_W] = r_tap[i];
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            r_cnt     <= '0;
            r_seen    <= '0;
            word_data <= '0;
            word_vld  <= 1'b0;
            skew_err  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_arr[i] <= '0;
                r_tap[i] <= '0;
                for (int k = 0; k < MAX_SKEW; k++) r_dly[i][k] <= '0;
            end
        end else begin
            skew_err <= w_timeout;
            word_vld <= w_emit;
            if (w_emit) word_data <= w_word;
            for (int i = 0; i < LANES; i++) begin
                r_dly[i][0] <= lane_byte_data[8*i +: 8];
                for (int k = 1; k < MAX_SKEW; k++) r_dly[i][k] <= r_dly[i][k-1];
                if (w_enterAligned) r_tap[i] <= w_newTap[i];
            end
            if (r_state == IDLE) begin
                r_cnt  <= '0;
                r_seen <= lane_byte_vld;
                for (int i = 0; i < LANES; i++) r_arr[i] <= '0;
            end else if (r_state == CAPTURE) begin
                r_cnt  <= w_cntInc;
                r_seen <= w_seenNext;
                for (int i = 0; i < LANES; i++) begin
                    if (w_newArr[i]) r_arr[i] <= w_cntInc;
                end
            end
        end
    end

endmodule

// File: tb/tb_lane_deskew_n.sv
// Scoreboard bench for lane_deskew_n: packets with chosen or random lane start
// offsets; expected words, skew errors and taps come from a packet-level model.
module tb_lane_deskew_n;

    localparam int LANES    = 4;
    localparam int MAX_SKEW = 3;
    localparam int SKW_W    = $clog2(MAX_SKEW + 1);

    logic                   sclk = 1'b0;
    logic                   s_rst;
    logic [LANES*8-1:0]     lane_byte_data;
    logic [LANES-1:0]       lane_byte_vld;
    logic                   packet_done;
    logic [LANES*8-1:0]     word_data;
    logic                   word_vld;
    logic                   skew_err;
    logic [LANES*SKW_W-1:0] lane_tap;

    int checks = 0;
    int errors = 0;
    logic [LANES*8-1:0] expWords [$];
    int expErrPending = 0;
    logic [7:0] laneBytes [LANES][64];
    int curOff [LANES];

    always #5 sclk = ~sclk;

    lane_deskew_n #(.LANES(LANES), .MAX_SKEW(MAX_SKEW)) dut (
        .sclk(sclk), .s_rst(s_rst),
        .lane_byte_data(lane_byte_data), .lane_byte_vld(lane_byte_vld),
        .packet_done(packet_done),
        .word_data(word_data), .word_vld(word_vld),
        .skew_err(skew_err), .lane_tap(lane_tap)
    );

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every presented word and skew_err pulse is matched against the scoreboard.
    always @(negedge sclk) begin
        if (!s_rst && word_vld) begin
            if (expWords.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected word: got %h expected none", word_data);
            end else begin
                checkOutput("word_data", 64'(word_data), 64'(expWords.pop_front()));
            end
        end
        if (!s_rst && skew_err) begin
            checks++;
            if (expErrPending > 0) expErrPending--;
            else begin
                errors++;
                $display("[TB] FAIL unexpected skew_err: got 1 expected 0");
            end
        end
    end

    function automatic int maxOffset();
        int m = 0;
        for (int i = 0; i < LANES; i++) if (curOff[i] > m) m = curOff[i];
        return m;
    endfunction

    // Lane i carries its byte stream from cycle curOff[i] up to endT.
    task automatic setInputs(input int t, input int endT, input int pdT);
        logic [LANES*8-1:0] d;
        logic [LANES-1:0]   v;
        for (int i = 0; i < LANES; i++) begin
            if (t >= curOff[i] && t < endT) begin
                v[i]       = 1'b1;
                d[8*i +: 8] = laneBytes[i][t - curOff[i]];
            end else begin
                v[i]       = 1'b0;
                d[8*i +: 8] = 8'($urandom);
            end
        end
        lane_byte_data = d;
        lane_byte_vld  = v;
        packet_done    = (t == pdT);
    endtask

    function automatic logic [LANES*8-1:0] modelWord(input int j);
        logic [LANES*8-1:0] w;
        for (int i = 0; i < LANES; i++) w[8*i +: 8] = laneBytes[i][j];
        return w;
    endfunction

    task automatic applyStimulus(input int pdT, input int tail);
        int maxOff = maxOffset();
        bit expErr = (maxOff > MAX_SKEW) && !(pdT >= 1 && pdT <= MAX_SKEW);
        int nWords = (maxOff <= MAX_SKEW && pdT > maxOff) ? pdT - maxOff : 0;
        int endT   = ((pdT > maxOff) ? pdT : maxOff) + 1 + tail;
        logic [LANES*SKW_W-1:0] expTap;
        for (int i = 0; i < LANES; i++)
            for (int j = 0; j < 64; j++) laneBytes[i][j] = 8'($urandom);
        for (int j = 0; j < nWords; j++) expWords.push_back(modelWord(j));
        if (expErr) expErrPending++;
        for (int t = 0; t < endT; t++) begin
            setInputs(t, endT, pdT);
            @(posedge sclk); #1;
        end
        setInputs(endT, endT, -1);
        repeat (2 + $urandom_range(0, 2)) begin
            @(posedge sclk); #1;
        end
        @(negedge sclk); #1;
        checkOutput("words outstanding", 64'(expWords.size()), 64'd0);
        checkOutput("skew_err outstanding", 64'(expErrPending), 64'd0);
        expWords.delete();
        expErrPending = 0;
        if (nWords > 0) begin
            for (int i = 0; i < LANES; i++) expTap[i*SKW_W +: SKW_W] = SKW_W'(maxOff - curOff[i]);
            checkOutput("lane_tap", 64'(lane_tap), 64'(expTap));
            checkOutput("word_data hold", 64'(word_data), 64'(modelWord(nWords - 1)));
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pdT, m;
        s_rst          = 1'b1;
        lane_byte_data = '0;
        lane_byte_vld  = '0;
        packet_done    = 1'b0;
        #12;
        checkOutput("reset word_vld", 64'(word_vld), 64'd0);
        checkOutput("reset word_data", 64'(word_data), 64'd0);
        checkOutput("reset skew_err", 64'(skew_err), 64'd0);
        checkOutput("reset lane_tap", 64'(lane_tap), 64'd0);
        @(negedge sclk); s_rst = 1'b0;
        @(posedge sclk); #1;

        $display("[TB] aligned start");
        curOff = '{0, 0, 0, 0};  applyStimulus(6, 2);
        $display("[TB] lane0 leads by 2");
        curOff = '{0, 2, 2, 2};  applyStimulus(6, 1);
        $display("[TB] over-skewed start");
        curOff = '{0, 1, 2, 4};  applyStimulus(8, 1);
        $display("[TB] packet_done with valid still high");
        curOff = '{1, 0, 3, 2};  applyStimulus(7, 3);
        $display("[TB] packet_done on timeout cycle");
        curOff = '{0, 0, 0, 5};  applyStimulus(3, 1);
        $display("[TB] skew exactly MAX_SKEW");
        curOff = '{3, 0, 1, 2};  applyStimulus(9, 0);

        $display("[TB] reset during ALIGNED");
        curOff = '{0, 1, 0, 0};
        for (int i = 0; i < LANES; i++)
            for (int j = 0; j < 64; j++) laneBytes[i][j] = 8'($urandom);
        for (int j = 0; j < 4; j++) expWords.push_back(modelWord(j));
        for (int t = 0; t < 5; t++) begin
            setInputs(t, 20, -1);
            @(posedge sclk); #1;
        end
        @(negedge sclk); #1;
        s_rst = 1'b1;
        #1;
        checkOutput("words before reset", 64'(expWords.size()), 64'd0);
        checkOutput("mid reset word_vld", 64'(word_vld), 64'd0);
        checkOutput("mid reset word_data", 64'(word_data), 64'd0);
        checkOutput("mid reset lane_tap", 64'(lane_tap), 64'd0);
        expWords.delete();
        lane_byte_vld = '0;
        packet_done   = 1'b0;
        @(negedge sclk); s_rst = 1'b0;
        @(posedge sclk); #1;
        curOff = '{0, 0, 0, 0};  applyStimulus(5, 1);

        $display("[TB] random packets");
        for (int p = 0; p < 40; p++) begin
            for (int i = 0; i < LANES; i++) curOff[i] = $urandom_range(0, 5);
            curOff[$urandom_range(0, LANES - 1)] = 0;
            m = maxOffset();
            if (m > MAX_SKEW)                              pdT = $urandom_range(1, 8);
            else if (m > 1 && $urandom_range(0, 3) == 0)   pdT = $urandom_range(1, m - 1);
            else                                           pdT = m + 1 + $urandom_range(0, 8);
            applyStimulus(pdT, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
